// File: rtl/inp_cond_pkg.sv
// Shared definitions for the input conditioner: bit positions of the
// button vector, coin FSM state encoding and parameter defaults.
package inp_cond_pkg;

  // Bit positions inside raw_in / inp_n
  localparam int P1RO   = 0;
  localparam int P1DW   = 1;
  localparam int P1RG   = 2;
  localparam int P1LF   = 3;
  localparam int P2RO   = 4;
  localparam int P2DW   = 5;
  localparam int P2RG   = 6;
  localparam int P2LF   = 7;
  localparam int COIN1  = 8;
  localparam int COIN2  = 9;
  localparam int SELFT  = 10;
  localparam int NUM_IN = 11;

  // Coin pulse sequencer states
  typedef enum logic [1:0] {
    COIN_IDLE    = 2'd0,
    COIN_PULSE   = 2'd1,
    COIN_WAITREL = 2'd2
  } coin_state_t;

  // Parameter defaults
  localparam logic [15:0] DEB_CYC_DEF     = 16'd500;
  localparam int          COIN_FRAMES_DEF = 3;
  localparam logic [31:0] DIM_CYC_DEF     = 32'h1DCD6500;

endpackage

// File: rtl/inp_debounce.sv
// One-bit conditioner: 2-flop synchroniser followed by an optional
// stability filter (INP_COND_DEBOUNCE_EN). 'rise' is high in the cycle
// whose clock edge will move 'stable' from 0 to 1, so consumers can act
// on the same edge that the debounced bit changes.
module inp_debounce
  import inp_cond_pkg::*;
#(
  parameter logic [15:0] DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic din,
  output logic stable,
  output logic rise
);

  logic sync1;
  logic sync2;

  // Two-stage synchroniser into clk_sys
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

`ifdef INP_COND_DEBOUNCE_EN
  logic [15:0] cnt;
  logic        hit;

  // The synchronised bit has differed from 'stable' for DEB_CYC edges
  assign hit  = (sync2 != stable) && (cnt == DEB_CYC - 16'd1);
  assign rise = hit & sync2;

  // Count consecutive cycles of disagreement; any return to agreement restarts it
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 16'd0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= 16'd0;
    end else if (hit) begin
      stable <= sync2;
      cnt    <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end
`else
  // No filtering: the synchroniser output is the debounced bit
  logic unused_deb;
  assign unused_deb = ^DEB_CYC;
  assign stable     = sync2;
  assign rise       = sync1 & ~sync2;
`endif

endmodule

// File: rtl/inp_cond.sv
// Input conditioner for the arcade core: synchronises and debounces the
// buttons (debounce enabled by macro INP_COND_DEBOUNCE_EN), turns each
// coin press into a fixed-length pulse counted in vblank edges, and
// produces pause / dim requests. coin_state exposes both coin FSMs
// ([1:0] coin1, [3:2] coin2) for observation.
module inp_cond
  import inp_cond_pkg::*;
#(
  parameter logic [15:0] DEB_CYC     = DEB_CYC_DEF,
  parameter int          COIN_FRAMES = COIN_FRAMES_DEF,
  parameter logic [31:0] DIM_CYC     = DIM_CYC_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] raw_in,
  input  logic        pause_btn,
  input  logic        vblank,
  input  logic        osd_open,
  input  logic        osd_pause_en,
  output logic [10:0] inp_n,
  output logic        pause,
  output logic        dim,
  output logic [3:0]  coin_state
);

  logic [11:0] pin;
  logic [11:0] db;
  logic [11:0] rise;
  logic        vb_q;
  logic        vb_rise;
  logic [1:0]  coin_low;
  logic        pause_toggle;
  logic [31:0] timer;
  logic        unused_rise;

  // Bit 11 carries the pause button through the same conditioning path
  assign pin         = {pause_btn, raw_in};
  assign unused_rise = ^{rise[7:0], rise[SELFT]};

  for (genvar i = 0; i < 12; i++) begin : g_deb
    inp_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .din     (pin[i]),
      .stable  (db[i]),
      .rise    (rise[i])
    );
  end

  // Delay vblank by one cycle to detect its rising edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) vb_q <= 1'b0;
    else          vb_q <= vblank;
  end
  assign vb_rise = vblank & ~vb_q;

  for (genvar c = 0; c < 2; c++) begin : g_coin
    coin_state_t st;
    logic [7:0]  fcnt;
    logic        low;

    // Coin sequencer: one pulse per press, length COIN_FRAMES vblank edges
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        st   <= COIN_IDLE;
        fcnt <= 8'd0;
        low  <= 1'b0;
      end else begin
        case (st)
          COIN_IDLE: begin
            if (rise[COIN1+c]) begin
              st   <= COIN_PULSE;
              fcnt <= 8'd0;
              low  <= 1'b1;
            end
          end
          COIN_PULSE: begin
            if (vb_rise) begin
              if (fcnt == 8'(COIN_FRAMES - 1)) begin
                st  <= COIN_WAITREL;
                low <= 1'b0;
              end else begin
                fcnt <= fcnt + 8'd1;
              end
            end
          end
          COIN_WAITREL: begin
            if (!db[COIN1+c]) st <= COIN_IDLE;
          end
          default: begin
            st  <= COIN_IDLE;
            low <= 1'b0;
          end
        endcase
      end
    end

    assign coin_low[c]          = low;
    assign coin_state[2*c +: 2] = st;
  end

  assign inp_n = {~db[SELFT], ~coin_low[1], ~coin_low[0], ~db[P2LF:P1RO]};

  // Pause toggle flips on each debounced pause press; pause adds the OSD request
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pause_toggle <= 1'b0;
      pause        <= 1'b0;
    end else begin
      if (rise[11]) pause_toggle <= ~pause_toggle;
      pause <= pause_toggle | (osd_open & osd_pause_en);
    end
  end

  // Dim timer runs only for a user pause and saturates at DIM_CYC
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)              timer <= 32'd0;
    else if (!pause_toggle)    timer <= 32'd0;
    else if (timer < DIM_CYC)  timer <= timer + 32'd1;
  end

  assign dim = (timer >= DIM_CYC);

endmodule

// File: tb/tb_inp_cond.sv
// Bench for inp_cond with DEB_CYC=4, COIN_FRAMES=2, DIM_CYC=10. A
// cycle-level reference model derives the debounced bits from a sliding
// window over the raw input history and tracks coin pulses, pause and dim
// with plain counters; directed sequences check the latencies and
// filtering, followed by a randomized run.
module tb_inp_cond;
  import inp_cond_pkg::*;

  localparam int DEB = 4;
  localparam int CF  = 2;
  localparam int DIM = 10;
`ifdef INP_COND_DEBOUNCE_EN
  localparam int LAT   = DEB + 2;
  localparam int GLEXP = -1;
`else
  localparam int LAT   = 2;
  localparam int GLEXP = 2;
`endif

  logic        clk_sys;
  logic        reset_n;
  logic [10:0] raw_in;
  logic        pause_btn;
  logic        vblank;
  logic        osd_open;
  logic        osd_pause_en;
  logic [10:0] inp_n;
  logic        pause;
  logic        dim;
  logic [3:0]  coin_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vb_per = 20;

  // Reference model state
  logic [11:0] hist_q[$];
  logic [11:0] m_db;
  int          m_left[2];
  bit          m_wait[2];
  bit          m_tog;
  bit          m_pause;
  int unsigned m_timer;
  logic        m_vb_q;
  logic [14:0] exp_q[$];

  inp_cond #(.DEB_CYC(16'(DEB)), .COIN_FRAMES(CF), .DIM_CYC(32'(DIM))) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .raw_in       (raw_in),
    .pause_btn    (pause_btn),
    .vblank       (vblank),
    .osd_open     (osd_open),
    .osd_pause_en (osd_pause_en),
    .inp_n        (inp_n),
    .pause        (pause),
    .dim          (dim),
    .coin_state   (coin_state)
  );

  // Clock
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist_q.delete();
    for (int i = 0; i < DEB + 2; i++) hist_q.push_back(12'd0);
    m_db    = 12'd0;
    m_left  = '{0, 0};
    m_wait  = '{0, 0};
    m_tog   = 1'b0;
    m_pause = 1'b0;
    m_timer = 0;
    m_vb_q  = 1'b0;
  endtask

  // Advance the model by one clock edge and queue the expected outputs
  task automatic model_update();
    logic [11:0] new_db, rs, w0, wi;
    logic [14:0] e;
    logic        vb_rise;
    bit          same;
    hist_q.push_back({pause_btn, raw_in});
    while (hist_q.size() > DEB + 2) void'(hist_q.pop_front());
`ifdef INP_COND_DEBOUNCE_EN
    // A bit adopts a value once DEB consecutive synchronised samples agree
    w0 = hist_q[0];
    for (int b = 0; b < 12; b++) begin
      same = 1'b1;
      for (int i = 1; i < DEB; i++) begin
        wi = hist_q[i];
        if (wi[b] != w0[b]) same = 1'b0;
      end
      new_db[b] = same ? w0[b] : m_db[b];
    end
`else
    new_db = hist_q[DEB];
`endif
    rs      = new_db & ~m_db;
    vb_rise = vblank & ~m_vb_q;
    m_vb_q  = vblank;
    for (int c = 0; c < 2; c++) begin
      if (m_left[c] > 0) begin
        if (vb_rise) begin
          m_left[c]--;
          if (m_left[c] == 0) m_wait[c] = 1'b1;
        end
      end else if (m_wait[c]) begin
        if (!m_db[8+c]) m_wait[c] = 1'b0;
      end else if (rs[8+c]) begin
        m_left[c] = CF;
      end
    end
    if (!m_tog) m_timer = 0;
    else if (m_timer < DIM) m_timer++;
    m_pause = m_tog | (osd_open & osd_pause_en);
    if (rs[11]) m_tog = ~m_tog;
    m_db = new_db;
    e[10:0] = ~m_db[10:0];
    e[8]    = !(m_left[0] > 0);
    e[9]    = !(m_left[1] > 0);
    e[11]   = m_pause;
    e[12]   = (m_timer >= DIM);
    e[13]   = (m_left[0] == 0) && !m_wait[0];
    e[14]   = (m_left[1] == 0) && !m_wait[1];
    exp_q.push_back(e);
  endtask

  // One clock: update model at the edge, compare 1 time unit later
  task automatic tick();
    logic [14:0] e;
    @(posedge clk_sys);
    if (reset_n) model_update();
    else exp_q.push_back({2'b11, 1'b0, 1'b0, 11'h7FF});
    #1;
    e = exp_q.pop_front();
    check("inp_n", 32'(inp_n), 32'(e[10:0]));
    check("pause", 32'(pause), 32'(e[11]));
    check("dim", 32'(dim), 32'(e[12]));
    check("coin1_idle", 32'(coin_state[1:0] == 2'(COIN_IDLE)), 32'(e[13]));
    check("coin2_idle", 32'(coin_state[3:2] == 2'(COIN_IDLE)), 32'(e[14]));
    cyc++;
    vblank = ((cyc % vb_per) < 2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_inp_n", 32'(inp_n), 32'h7FF);
    check("rst_pause", 32'(pause), 32'd0);
    check("rst_dim", 32'(dim), 32'd0);
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Drive raw_in[b] high for 'hold' cycles; report first cycle inp_n[b] is low
  task automatic measure_low(input int b, input int hold, input int span, output int first);
    first = -1;
    raw_in[b] = 1'b1;
    for (int k = 1; k <= span; k++) begin
      tick();
      if (first < 0 && inp_n[b] == 1'b0) first = k;
      if (k == hold) raw_in[b] = 1'b0;
    end
  endtask

  initial begin
    int first;
    int pulses;
    logic prev;
    raw_in       = 11'd0;
    pause_btn    = 1'b0;
    vblank       = 1'b0;
    osd_open     = 1'b0;
    osd_pause_en = 1'b0;
    reset_n      = 1'b0;
    do_reset();
    ticks(10);

    // Debounce latency and glitch filtering
    measure_low(P1RO, 20, 25, first);
    check("lat_bit0", 32'(first), 32'(LAT));
    ticks(10);
    measure_low(P1DW, 3, 15, first);
    check("glitch3_bit1", 32'(first), 32'(GLEXP));
    ticks(10);
    measure_low(P1RG, 1, 10, first);
    check("glitch1_bit2", 32'(first), 32'(GLEXP));
    ticks(10);
    measure_low(P1RG, 20, 25, first);
    check("lat_bit2", 32'(first), 32'(LAT));
    ticks(10);

    // Coin held 100 cycles gives one pulse; re-press gives another
    pulses = 0;
    prev = 1'b1;
    raw_in[COIN1] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (prev && !inp_n[COIN1]) pulses++;
      prev = inp_n[COIN1];
    end
    check("coin_hold_pulses", 32'(pulses), 32'd1);
    check("coin_after_pulse", 32'(inp_n[COIN1]), 32'd1);
    raw_in[COIN1] = 1'b0;
    ticks(20);
    raw_in[COIN1] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (prev && !inp_n[COIN1]) pulses++;
      prev = inp_n[COIN1];
    end
    check("coin_repress_pulses", 32'(pulses), 32'd2);
    raw_in[COIN1] = 1'b0;
    ticks(20);

    // Pause on: dim after DIM cycles of toggle; pause off: both clear
    first = -1;
    pulses = -1;
    pause_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (pulses < 0 && pause) pulses = k;
      if (first < 0 && dim) first = k;
      if (k == 10) pause_btn = 1'b0;
    end
    check("pause_on_lat", 32'(pulses), 32'(LAT + 1));
    check("dim_on_lat", 32'(first), 32'(LAT + DIM));
    first = -1;
    pause_btn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (first < 0 && !dim) first = k;
      if (k == 10) pause_btn = 1'b0;
    end
    check("dim_off_lat", 32'(first), 32'(LAT + 1));
    check("pause_off", 32'(pause), 32'd0);

    // OSD-only pause never dims
    osd_open = 1'b1;
    osd_pause_en = 1'b1;
    tick();
    check("osd_pause", 32'(pause), 32'd1);
    ticks(20);
    check("osd_no_dim", 32'(dim), 32'd0);
    osd_pause_en = 1'b0;
    tick();
    check("osd_pause_off", 32'(pause), 32'd0);
    osd_open = 1'b0;
    ticks(5);

    // Reset during a coin pulse and a user pause
    pause_btn = 1'b1;
    ticks(10);
    pause_btn = 1'b0;
    ticks(10);
    raw_in[COIN2] = 1'b1;
    first = -1;
    for (int k = 1; k <= 30 && first < 0; k++) begin
      tick();
      if (!inp_n[COIN2]) first = k;
    end
    check("coin2_started", 32'(first > 0), 32'd1);
    tick();
    do_reset();
    measure_low(COIN2, 1000, 10, first);
    check("coin2_after_reset", 32'(first), 32'(LAT));
    raw_in[COIN2] = 1'b0;
    ticks(40);

    // Randomized run against the model
    vb_per = $urandom_range(8, 24);
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 11; b++)
        if ($urandom_range(0, 15) == 0) raw_in[b] = ~raw_in[b];
      if ($urandom_range(0, 15) == 0) pause_btn = ~pause_btn;
      if ($urandom_range(0, 31) == 0) osd_open = ~osd_open;
      if ($urandom_range(0, 31) == 0) osd_pause_en = ~osd_pause_en;
      if ($urandom_range(0, 999) == 0) do_reset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
